// File: rtl/simple_pkg.sv
// Shared types and defaults for the CPU run-control front end.
package simple_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        RUN,
        STOPPING,
        HALT
    } state_t;

    // Phase counter enable is asserted whenever an instruction may be in flight.
    function automatic logic state_exec(input state_t s);
        return (s == STEP) || (s == RUN) || (s == STOPPING);
    endfunction

    function automatic logic state_running(input state_t s);
        return (s == RUN) || (s == STOPPING);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted 0->1 transition of the stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            stable;
    logic [DB_W-1:0] count;

    // Synchronize, then accept a new level only after it has held long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            stable  <= 1'b0;
            count   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 != stable) begin
                if (count == LAST) begin
                    stable <= sync_q2;
                    count  <= '0;
                    press  <= sync_q2;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Run control in front of the phase counter: single-step, free-run and halt.
// Optional feature macro: BREAKPOINT_EN (stop RUN after the instruction at bp_addr).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped, exec low, waiting for a step or run press
// STEP     | executing exactly one instruction
// RUN      | free-running until a press, halt or breakpoint
// STOPPING | stop requested, finishing the current instruction
// HALT     | halt instruction retired; only reset leaves
module exec_sequencer
    import simple_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int ADDR_W          = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exec_btn,
    input  logic              mode_btn,
    input  logic              instr_done,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              exec,
    output logic              running,
    output logic              halted,
    output logic              bp_hit
);

    state_t state;
    state_t state_nxt;
    logic   exec_press;
    logic   mode_press;
    logic   bp_match;
    logic   bp_stop;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_exec_db (
        .clk  (clk),
        .reset(reset),
        .btn  (exec_btn),
        .press(exec_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_mode_db (
        .clk  (clk),
        .reset(reset),
        .btn  (mode_btn),
        .press(mode_press)
    );

`ifdef BREAKPOINT_EN
    assign bp_match = instr_done && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
    assign bp_match  = 1'b0;
`endif

    // Next-state decision; stops are only taken on an instruction boundary.
    always_comb begin
        state_nxt = state;
        bp_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (exec_press) begin
                    state_nxt = STEP;
                end else if (mode_press) begin
                    state_nxt = RUN;
                end
            end
            STEP: begin
                if (instr_done) begin
                    state_nxt = halt_req ? HALT : IDLE;
                end
            end
            RUN: begin
                if (instr_done && halt_req) begin
                    state_nxt = HALT;
                end else if (bp_match) begin
                    state_nxt = IDLE;
                    bp_stop   = 1'b1;
                end else if (exec_press || mode_press) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (instr_done) begin
                    state_nxt = halt_req ? HALT : IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and all outputs advance together so exec drops on the edge
    // that ends the instr_done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            exec    <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            state   <= state_nxt;
            exec    <= state_exec(state_nxt);
            running <= state_running(state_nxt);
            halted  <= (state_nxt == HALT);
            bp_hit  <= bp_stop;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer with a 6-clock phase counter model.
module tb_exec_sequencer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          exec_btn;
    logic          mode_btn;
    logic          instr_done;
    logic          halt_req;
    logic [AW-1:0] pc;
    logic [AW-1:0] bp_addr;
    logic          exec;
    logic          running;
    logic          halted;
    logic          bp_hit;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [4:0]    exp_q[$];
    int            phase;

    exec_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (4),
        .ADDR_W         (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .exec_btn  (exec_btn),
        .mode_btn  (mode_btn),
        .instr_done(instr_done),
        .halt_req  (halt_req),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .exec      (exec),
        .running   (running),
        .halted    (halted),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    // Phase counter model: while exec is high, one instr_done every 6 clocks;
    // pc advances after each retired instruction.
    initial begin
        phase      = 0;
        instr_done = 1'b0;
        pc         = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase      = 0;
                instr_done = 1'b0;
                pc         = '0;
            end else begin
                if (instr_done) begin
                    instr_done = 1'b0;
                    pc         = pc + 1'b1;
                end
                if (exec) begin
                    phase++;
                    if (phase == 6) begin
                        phase      = 0;
                        instr_done = 1'b1;
                    end
                end else begin
                    phase = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs, expv;
        exp_q.delete();
        exp_q.push_back(5'b00000);
        reset = 1'b1;
        tick();
        tick();
        obs  = {exec, running, halted, bp_hit, instr_done};
        expv = exp_q.pop_front();
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL reset_outputs: got %b expected %b", obs, expv);
        end
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_glitch();
        logic [4:0] obs, expv;
        int seen_exec = 0;
        exp_q.delete();
        exp_q.push_back(5'b00000);
        exec_btn = 1'b1;
        repeat (3) tick();
        exec_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (exec || running) seen_exec++;
        end
        n_cmp++;
        if (seen_exec !== 0) begin
            n_mis++;
            $display("FAIL glitch_no_exec: got %0d active cycles expected 0", seen_exec);
        end
        obs  = {exec, running, halted, bp_hit, instr_done};
        expv = exp_q.pop_front();
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL glitch_state: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_step();
        logic [4:0] obs, expv;
        int  n_done = 0;
        int  n_exec = 0;
        bit  rose   = 0;
        bit  fell   = 0;
        exp_q.delete();
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b00001);
        exec_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 9) exec_btn = 1'b0;
            obs = {exec, running, halted, bp_hit, instr_done};
            if (exec) n_exec++;
            if (instr_done) n_done++;
            if (exec && !rose) begin
                rose = 1;
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL step_start: got %b expected %b", obs, expv);
                end
            end
            if (rose && !exec && !fell) begin
                fell = 1;
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL step_end: got %b expected %b", obs, expv);
                end
            end
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_mis++;
            $display("FAIL step_instr_count: got %0d expected 1", n_done);
        end
        n_cmp++;
        if (n_exec !== 6) begin
            n_mis++;
            $display("FAIL step_exec_cycles: got %0d expected 6", n_exec);
        end
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL step_timeout: got no event expected %b", expv);
        end
        repeat (12) tick();
    endtask

    task automatic test_simul_press();
        logic [4:0] obs, expv;
        int  n_exec = 0;
        bit  rose   = 0;
        bit  fell   = 0;
        exp_q.delete();
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b00001);
        exec_btn = 1'b1;
        mode_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 7) begin
                exec_btn = 1'b0;
                mode_btn = 1'b0;
            end
            obs = {exec, running, halted, bp_hit, instr_done};
            if (exec) n_exec++;
            if (exec && !rose) begin
                rose = 1;
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL simul_exec_wins: got %b expected %b", obs, expv);
                end
            end
            if (rose && !exec && !fell) begin
                fell = 1;
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL simul_end: got %b expected %b", obs, expv);
                end
            end
        end
        n_cmp++;
        if (n_exec !== 6) begin
            n_mis++;
            $display("FAIL simul_exec_cycles: got %0d expected 6", n_exec);
        end
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL simul_timeout: got no event expected %b", expv);
        end
        repeat (12) tick();
    endtask

    task automatic test_run_stop();
        logic [4:0] obs, expv;
        int  n_done = 0;
        bit  rose   = 0;
        bit  got_id = 0;
        bit  fell   = 0;
        exp_q.delete();
        exp_q.push_back(5'b11000);
        exp_q.push_back(5'b00001);
        bp_addr  = 12'hFFF;
        mode_btn = 1'b1;
        for (int i = 0; i < 30 && !rose; i++) begin
            tick();
            if (i == 7) mode_btn = 1'b0;
            if (running) begin
                rose = 1;
                obs  = {exec, running, halted, bp_hit, instr_done};
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL run_start: got %b expected %b", obs, expv);
                end
            end
        end
        mode_btn = 1'b0;
        for (int i = 0; i < 10 && rose && !got_id; i++) begin
            tick();
            if (instr_done) got_id = 1;
        end
        if (got_id) begin
            exec_btn = 1'b1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (i == 7) exec_btn = 1'b0;
                if (!fell) begin
                    if (instr_done) n_done++;
                    if (!exec) begin
                        fell = 1;
                        obs  = {exec, running, halted, bp_hit, instr_done};
                        expv = exp_q.pop_front();
                        n_cmp++;
                        if (obs !== expv) begin
                            n_mis++;
                            $display("FAIL run_stop_boundary: got %b expected %b", obs, expv);
                        end
                    end
                end
            end
            exec_btn = 1'b0;
            n_cmp++;
            if (n_done !== 2) begin
                n_mis++;
                $display("FAIL run_stop_instr_count: got %0d expected 2", n_done);
            end
        end
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL run_timeout: got no event expected %b", expv);
        end
        repeat (12) tick();
    endtask

    task automatic test_reset_mid_run();
        logic [4:0] obs, expv;
        bit rose = 0;
        exp_q.delete();
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        mode_btn = 1'b1;
        for (int i = 0; i < 30 && !rose; i++) begin
            tick();
            if (i == 7) mode_btn = 1'b0;
            if (running) rose = 1;
        end
        mode_btn = 1'b0;
        if (!rose) begin
            n_cmp++;
            n_mis++;
            $display("FAIL rstmid_run_start: got running=0 expected 1");
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        obs  = {exec, running, halted, bp_hit, instr_done};
        expv = exp_q.pop_front();
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL rstmid_next_cycle: got %b expected %b", obs, expv);
        end
        reset = 1'b0;
        repeat (10) tick();
        obs  = {exec, running, halted, bp_hit, instr_done};
        expv = exp_q.pop_front();
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL rstmid_stays_idle: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_breakpoint();
        logic [4:0] obs, expv;
        bit  rose  = 0;
        bit  fell  = 0;
        int  n_bp  = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bp_addr  = 12'h005;
        halt_req = 1'b0;
        exp_q.delete();
`ifdef BREAKPOINT_EN
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
`else
        exp_q.push_back(5'b11000);
`endif
        mode_btn = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (i == 7) mode_btn = 1'b0;
            obs = {exec, running, halted, bp_hit, instr_done};
            if (bp_hit) n_bp++;
            if (running) rose = 1;
`ifdef BREAKPOINT_EN
            if (rose && !running && !fell) begin
                fell = 1;
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL bp_stop: got %b expected %b", obs, expv);
                end
                n_cmp++;
                if (pc !== 12'h005) begin
                    n_mis++;
                    $display("FAIL bp_stop_pc: got %h expected 005", pc);
                end
                tick();
                obs  = {exec, running, halted, bp_hit, instr_done};
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL bp_hit_one_cycle: got %b expected %b", obs, expv);
                end
            end
`endif
        end
`ifdef BREAKPOINT_EN
        n_cmp++;
        if (n_bp !== 1) begin
            n_mis++;
            $display("FAIL bp_hit_count: got %0d expected 1", n_bp);
        end
`else
        obs  = {exec, running, halted, bp_hit, instr_done};
        obs[0] = 1'b0;
        expv = exp_q.pop_front();
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL bp_disabled_runs_on: got %b expected %b", obs, expv);
        end
        n_cmp++;
        if (n_bp !== 0 || pc <= 12'h005) begin
            n_mis++;
            $display("FAIL bp_disabled_no_hit: got bp_hits=%0d pc=%h expected 0 hits and pc past 005", n_bp, pc);
        end
`endif
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL bp_timeout: got no event expected %b", expv);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_halt();
        logic [4:0] obs, expv;
        bit  hit  = 0;
        int  n_bp = 0;
        int  left = 0;
        exp_q.delete();
        exp_q.push_back(5'b00101);
        exp_q.push_back(5'b00100);
        halt_req = 1'b1;
        bp_addr  = 12'h000;
        mode_btn = 1'b1;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (i == 7) mode_btn = 1'b0;
            if (bp_hit) n_bp++;
            if (halted) begin
                hit  = 1;
                obs  = {exec, running, halted, bp_hit, instr_done};
                expv = exp_q.pop_front();
                n_cmp++;
                if (obs !== expv) begin
                    n_mis++;
                    $display("FAIL halt_enter: got %b expected %b", obs, expv);
                end
            end
        end
        mode_btn = 1'b0;
        if (hit) begin
            exec_btn = 1'b1;
            mode_btn = 1'b1;
            repeat (8) tick();
            exec_btn = 1'b0;
            mode_btn = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (!halted || exec) left++;
                if (bp_hit) n_bp++;
            end
            obs  = {exec, running, halted, bp_hit, instr_done};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv || left !== 0) begin
                n_mis++;
                $display("FAIL halt_absorbing: got %b (left %0d) expected %b", obs, left, expv);
            end
            n_cmp++;
            if (n_bp !== 0) begin
                n_mis++;
                $display("FAIL halt_over_bp: got %0d bp_hit cycles expected 0", n_bp);
            end
        end
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL halt_timeout: got no event expected %b", expv);
        end
        halt_req = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset    = 1'b1;
        exec_btn = 1'b0;
        mode_btn = 1'b0;
        halt_req = 1'b0;
        bp_addr  = 12'hFFF;
        test_reset();
        test_glitch();
        test_step();
        test_simul_press();
        test_run_stop();
        test_reset_mid_run();
        test_breakpoint();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
